// File: rtl/trace_pkt_serializer_pkg.sv
// Shared types for the retire-trace serializer.
//   TRACE_LANES  number of retire lanes in a trace packet
//   trace_pkt_t  retire trace packet as produced by the core (3 lanes)
//   trace_rec_t  one per-instruction record (103 bits)
//   lane_rec()   extracts one lane of a packet as a record
package trace_pkt_serializer_pkg;

  localparam int TRACE_LANES = 3;

  typedef struct packed {
    logic [95:0] trace_rv_i_insn_ip;
    logic [95:0] trace_rv_i_address_ip;
    logic [2:0]  trace_rv_i_valid_ip;
    logic [2:0]  trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic [2:0]  trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } trace_pkt_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } trace_rec_t;

  typedef logic [1:0] lane_idx_t;

  // ecause/tval are shared across lanes; only a trapping lane carries them.
  function automatic trace_rec_t lane_rec(input trace_pkt_t pkt, input lane_idx_t lane);
    trace_rec_t r;
    logic       trap;
    r.insn   = pkt.trace_rv_i_insn_ip[32*lane +: 32];
    r.addr   = pkt.trace_rv_i_address_ip[32*lane +: 32];
    r.exc    = pkt.trace_rv_i_exception_ip[lane];
    r.intr   = pkt.trace_rv_i_interrupt_ip[lane];
    trap     = r.exc | r.intr;
    r.ecause = trap ? pkt.trace_rv_i_ecause_ip : 5'd0;
    r.tval   = trap ? pkt.trace_rv_i_tval_ip : 32'd0;
    return r;
  endfunction

endpackage

// File: rtl/trace_lane_compact.sv
// Combinational lane compaction.
//   valid      per-lane valid bits of the incoming packet
//   slot_lane  for each output slot, the lane feeding it (valid lanes packed low, lane0 first)
//   n_push     number of valid lanes (0..3)
// Slots at or above n_push carry don't-care lane selects.
module trace_lane_compact
  import trace_pkt_serializer_pkg::*;
(
  input  logic [TRACE_LANES-1:0] valid,
  output lane_idx_t              slot_lane [TRACE_LANES],
  output logic [1:0]             n_push
);

  logic [1:0] k;

  always_comb begin
    k = 2'd0;
    for (int s = 0; s < TRACE_LANES; s++) slot_lane[s] = 2'd0;
    for (int i = 0; i < TRACE_LANES; i++) begin
      if (valid[i]) begin
        slot_lane[k] = lane_idx_t'(i);
        k            = k + 2'd1;
      end
    end
    n_push = k;
  end

endmodule

// File: rtl/trace_pkt_serializer.sv
// Retire-trace serializer: splits each trace packet into per-instruction
// records, queues them in a FIFO and emits one record per cycle.
//   clk, rst            clock, asynchronous active-high reset
//   trace_in            retire packet, sampled every cycle (no backpressure)
//   rec_valid/ready     output handshake; rec_data is the head record
//   ovf, drop_cnt       sticky overflow flag and saturating dropped-packet count
//   ovf_clr             clears ovf/drop_cnt (a same-cycle drop takes priority)
//   occupancy           current FIFO entry count
module trace_pkt_serializer
  import trace_pkt_serializer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  trace_pkt_t                 trace_in,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output trace_rec_t                 rec_data,
  output logic                       ovf,
  output logic [CNT_W-1:0]           drop_cnt,
  input  logic                       ovf_clr,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  trace_rec_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  lane_idx_t        slot_lane [TRACE_LANES];
  trace_rec_t       slot_rec  [TRACE_LANES];
  logic [1:0]       n_push;
  logic [OCC_W-1:0] free_slots;
  logic             accept;
  logic             drop;
  logic             pop;

  trace_lane_compact u_compact (
    .valid     (trace_in.trace_rv_i_valid_ip),
    .slot_lane (slot_lane),
    .n_push    (n_push)
  );

  // Space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
  always_comb begin
    for (int s = 0; s < TRACE_LANES; s++) slot_rec[s] = lane_rec(trace_in, slot_lane[s]);
    free_slots = OCC_W'(DEPTH) - occupancy;
    accept     = (OCC_W'(n_push) <= free_slots);
    drop       = (n_push != 2'd0) && !accept;
    rec_valid  = (occupancy != '0);
    pop        = rec_valid && rec_ready;
    rec_data   = rec_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int s = 0; s < TRACE_LANES; s++) begin
        if (s < int'(n_push)) mem[wr_ptr + PTR_W'(s)] <= slot_rec[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy <= occupancy + (accept ? OCC_W'(n_push) : OCC_W'(0)) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_clr)        drop_cnt <= CNT_W'(1);
      else if (!(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_trace_pkt_serializer.sv
// Directed bench for trace_pkt_serializer with a queue-based reference model.
module tb_trace_pkt_serializer;
  import trace_pkt_serializer_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  trace_pkt_t       trace_in = '0;
  logic             rec_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             rec_valid;
  trace_rec_t       rec_data;
  logic             ovf;
  logic [CNT_W-1:0] drop_cnt;
  logic [$clog2(DEPTH):0] occupancy;

  trace_pkt_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .trace_in  (trace_in),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .ovf_clr   (ovf_clr),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  trace_rec_t       mq[$];
  logic             m_ovf = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic trace_rec_t rec_of(input trace_pkt_t p, input int i);
    trace_rec_t r;
    r.insn = p.trace_rv_i_insn_ip[32*i +: 32];
    r.addr = p.trace_rv_i_address_ip[32*i +: 32];
    r.exc  = p.trace_rv_i_exception_ip[i];
    r.intr = p.trace_rv_i_interrupt_ip[i];
    if (r.exc || r.intr) begin
      r.ecause = p.trace_rv_i_ecause_ip;
      r.tval   = p.trace_rv_i_tval_ip;
    end else begin
      r.ecause = 5'd0;
      r.tval   = 32'd0;
    end
    return r;
  endfunction

  function automatic trace_pkt_t mk(input logic [2:0] v, input logic [31:0] tag);
    trace_pkt_t p;
    p = '0;
    p.trace_rv_i_valid_ip = v;
    for (int i = 0; i < 3; i++) begin
      p.trace_rv_i_insn_ip[32*i +: 32]    = tag + 32'(i);
      p.trace_rv_i_address_ip[32*i +: 32] = 32'h8000_0000 + (tag << 4) + 32'(4 * i);
    end
    return p;
  endfunction

  task automatic check_model();
    chk("rec_valid", {127'd0, rec_valid}, {127'd0, mq.size() != 0});
    chk("occupancy", 128'(occupancy), 128'(mq.size()));
    if (mq.size() != 0) chk("rec_data", 128'(rec_data), 128'(mq[0]));
    chk("ovf", {127'd0, ovf}, {127'd0, m_ovf});
    chk("drop_cnt", 128'(drop_cnt), 128'(m_cnt));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input trace_pkt_t p, input logic rdy, input logic clr);
    trace_rec_t recs[$];
    int occ0;
    bit do_pop;
    bit acc;
    trace_in  = p;
    rec_ready = rdy;
    ovf_clr   = clr;
    #1;
    check_model();
    occ0   = mq.size();
    do_pop = (occ0 != 0) && rdy;
    for (int i = 0; i < 3; i++) if (p.trace_rv_i_valid_ip[i]) recs.push_back(rec_of(p, i));
    acc = (recs.size() <= DEPTH - occ0);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (acc) begin
      foreach (recs[k]) mq.push_back(recs[k]);
      if (clr) begin
        m_ovf = 1'b0;
        m_cnt = '0;
      end
    end else begin
      m_ovf = 1'b1;
      if (clr) m_cnt = CNT_W'(1);
      else if (m_cnt != '1) m_cnt = m_cnt + CNT_W'(1);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(mk(3'b000, 32'd0), rdy, 1'b0);
  endtask

  trace_pkt_t p;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {127'd0, rec_valid}, 128'd0);
    chk("rst_occ", 128'(occupancy), 128'd0);
    chk("rst_ovf", {127'd0, ovf}, 128'd0);
    chk("rst_cnt", 128'(drop_cnt), 128'd0);
    chk("rst_data", 128'(rec_data), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // single lane
    p = mk(3'b001, 32'd0);
    p.trace_rv_i_insn_ip[31:0]    = 32'h0000_0013;
    p.trace_rv_i_address_ip[31:0] = 32'h8000_0000;
    step(p, 1'b1, 1'b0);
    chk("single_valid", {127'd0, rec_valid}, 128'd1);
    chk("single_rec", 128'(rec_data), 128'({32'h13, 32'h8000_0000, 1'b0, 1'b0, 5'd0, 32'd0}));
    idle(1'b1);
    chk("single_occ", 128'(occupancy), 128'd0);

    // compaction
    p = mk(3'b101, 32'h50);
    p.trace_rv_i_insn_ip[31:0]  = 32'hA;
    p.trace_rv_i_insn_ip[95:64] = 32'hC;
    step(p, 1'b1, 1'b0);
    chk("compact_first", 128'(rec_data.insn), 128'h0A);
    chk("compact_occ", 128'(occupancy), 128'd2);
    idle(1'b1);
    chk("compact_second", 128'(rec_data.insn), 128'h0C);
    idle(1'b1);
    chk("compact_empty", {127'd0, rec_valid}, 128'd0);

    // exception gating
    p = mk(3'b011, 32'h100);
    p.trace_rv_i_exception_ip = 3'b010;
    p.trace_rv_i_ecause_ip    = 5'd2;
    p.trace_rv_i_tval_ip      = 32'hDEAD;
    step(p, 1'b1, 1'b0);
    chk("exc_lane0", 128'({rec_data.exc, rec_data.intr, rec_data.ecause, rec_data.tval}), 128'd0);
    idle(1'b1);
    chk("exc_lane1", 128'({rec_data.exc, rec_data.intr, rec_data.ecause, rec_data.tval}),
        128'({1'b1, 1'b0, 5'd2, 32'hDEAD}));
    idle(1'b1);

    // overflow
    step(mk(3'b111, 32'h200), 1'b0, 1'b0);
    step(mk(3'b111, 32'h210), 1'b0, 1'b0);
    step(mk(3'b111, 32'h220), 1'b0, 1'b0);
    chk("ovf_occ6", 128'(occupancy), 128'd6);
    chk("ovf_flag", {127'd0, ovf}, 128'd1);
    chk("ovf_cnt1", 128'(drop_cnt), 128'd1);
    step(mk(3'b011, 32'h230), 1'b0, 1'b0);
    chk("ovf_occ8", 128'(occupancy), 128'd8);
    step(mk(3'b001, 32'h240), 1'b0, 1'b0);
    chk("full_cnt2", 128'(drop_cnt), 128'd2);
    step(mk(3'b100, 32'h250), 1'b0, 1'b1);
    chk("clr_drop_cnt", 128'(drop_cnt), 128'd1);
    chk("clr_drop_ovf", {127'd0, ovf}, 128'd1);
    repeat (8) idle(1'b1);
    step(mk(3'b000, 32'd0), 1'b1, 1'b1);
    chk("clr_ovf", {127'd0, ovf}, 128'd0);
    chk("clr_cnt", 128'(drop_cnt), 128'd0);

    // wrap and concurrency
    for (int c = 0; c < 20; c++) step(mk(3'b111, 32'h1000 + 32'(16 * c)), 1'b1, 1'b0);
    chk("wrap_drops", 128'(drop_cnt), 128'd12);
    repeat (6) idle(1'b1);
    step(mk(3'b000, 32'd0), 1'b1, 1'b1);

    // asynchronous reset mid-stream
    step(mk(3'b111, 32'h300), 1'b0, 1'b0);
    step(mk(3'b111, 32'h310), 1'b0, 1'b0);
    step(mk(3'b111, 32'h320), 1'b0, 1'b0);
    idle(1'b1);
    chk("pre_rst_occ", 128'(occupancy), 128'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {127'd0, rec_valid}, 128'd0);
    chk("arst_occ", 128'(occupancy), 128'd0);
    chk("arst_ovf", {127'd0, ovf}, 128'd0);
    chk("arst_cnt", 128'(drop_cnt), 128'd0);
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    step(mk(3'b010, 32'h400), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
